sync_ram_dp: RTL

Parametrised synchronous simple-dual-port RAM: one write port with per-byte write mask and one read port with a valid-tagged, fixed-latency pipeline. Successor to the simulation-only asynchronous RAM; serves as register-file, instruction and data memory for the mini-RISC16 core on FPGA and in simulation. Adds write-first forwarding and an optional post-reset clear sweep.

---
 rtl/ram_pkg.sv | 19 +
 rtl/sync_ram_dp_if.sv | 40 ++++
 rtl/sync_ram_read_pipe.sv | 64 ++++++
 rtl/sync_ram_dp.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the sync_ram_dp memory block: controller state
// encoding, lane-count helper and the legal read-latency range.
package ram_pkg;

  // Controller state. RAM_INIT only exists when the clear sweep is built in.
  typedef enum logic {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  // Number of write-mask lanes in a word.
  function automatic int lane_count(input int word_width, input int byte_width);
    return word_width / byte_width;
  endfunction

endpackage

// File: rtl/sync_ram_dp_if.sv
// Bus bundle for sync_ram_dp: one masked write port and one read port.
//
// Handshake: a request (WriteEnable and/or ReadEnable) is accepted on a
// rising Clock edge only when Ready is high at that edge; requests while
// Ready is low are dropped, not held. Every accepted read produces exactly
// one ReadValid pulse (one cycle wide) a fixed number of edges later, in
// request order. There is no back-pressure on the read result.
interface sync_ram_dp_if
  import ram_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8
);
  localparam int LANES = lane_count(WORD_WIDTH, BYTE_WIDTH);

  logic                  Ready;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [WORD_WIDTH-1:0] WriteData;
  logic [LANES-1:0]      WriteMask;
  logic                  ReadEnable;
  logic [ADDR_WIDTH-1:0] ReadAddr;
  logic [WORD_WIDTH-1:0] ReadData;
  logic                  ReadValid;
  ram_state_e            DbgState;

  // Requester side (core / testbench).
  modport master (
    input  Ready, ReadData, ReadValid, DbgState,
    output WriteEnable, WriteAddr, WriteData, WriteMask, ReadEnable, ReadAddr
  );

  // Memory side.
  modport slave (
    output Ready, ReadData, ReadValid, DbgState,
    input  WriteEnable, WriteAddr, WriteData, WriteMask, ReadEnable, ReadAddr
  );

endinterface

// File: rtl/sync_ram_read_pipe.sv
// Read-result delay line for sync_ram_dp. Holds the output register
// (ReadData keeps its last valid value) plus an optional extra stage when
// READ_LATENCY is 2. All valid bits are cleared by nReset so in-flight reads
// are discarded.
module sync_ram_read_pipe
  import ram_pkg::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  valid_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] data_o
);

  logic                  stage_valid;
  logic [WORD_WIDTH-1:0] stage_data;
  logic                  valid_q;
  logic [WORD_WIDTH-1:0] data_q;

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("sync_ram_read_pipe: READ_LATENCY must be 1 or 2");
  end

  if (READ_LATENCY == 2) begin : g_extra_stage
    logic                  mid_valid_q;
    logic [WORD_WIDTH-1:0] mid_data_q;

    // Extra pipeline stage; data only advances with a valid result.
    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        mid_valid_q <= 1'b0;
        mid_data_q  <= '0;
      end else begin
        mid_valid_q <= valid_i;
        if (valid_i) mid_data_q <= data_i;
      end
    end

    assign stage_valid = mid_valid_q;
    assign stage_data  = mid_data_q;
  end else begin : g_direct
    assign stage_valid = valid_i;
    assign stage_data  = data_i;
  end

  // Output register: ReadValid pulses per result, ReadData holds between them.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= stage_valid;
      if (stage_valid) data_q <= stage_data;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sync_ram_dp.sv
// Synchronous simple-dual-port RAM with per-lane write mask, write-first
// forwarding for same-address collisions and a fixed-latency, valid-tagged
// read result.
// Optional feature macro: SYNC_RAM_CLEAR_ON_RESET_EN -- when defined, every
// reset runs a clear sweep (one word per cycle) before Ready asserts; when
// undefined, contents are retained across reset.
module sync_ram_dp
  import ram_pkg::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic         Clock,
  input  logic         nReset,
  sync_ram_dp_if.slave bus
);

  localparam int LANES = lane_count(WORD_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sync_ram_dp: WORD_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic                  ready_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  rd_valid_q;
  logic [WORD_WIDTH-1:0] rd_data_q;
  logic                  pipe_valid;
  logic [WORD_WIDTH-1:0] pipe_data;
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

`ifdef SYNC_RAM_CLEAR_ON_RESET_EN
  ram_state_e            state_q;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic                  sweep_we;

  // INIT clears one word per edge; Ready rises on the edge clearing DEPTH-1.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= RAM_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RAM_INIT: begin
          sweep_q <= sweep_q + ADDR_WIDTH'(1);
          if (sweep_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q <= RAM_RUN;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  assign sweep_we     = (state_q == RAM_INIT);
  assign bus.DbgState = state_q;

  // Storage: sweep clear has priority (Ready is low then anyway), else masked write.
  always_ff @(posedge Clock) begin
    if (sweep_we) begin
      mem_q[sweep_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.WriteMask[i])
          mem_q[bus.WriteAddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.WriteData[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end
`else
  // Without the sweep the block is usable from the first edge after reset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  assign bus.DbgState = RAM_RUN;

  // Storage: masked write, unmasked lanes keep their contents.
  always_ff @(posedge Clock) begin
    if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.WriteMask[i])
          mem_q[bus.WriteAddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.WriteData[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end
`endif

  assign bus.Ready = ready_q;
  assign wr_acc    = ready_q & bus.WriteEnable;
  assign rd_acc    = ready_q & bus.ReadEnable;

  // Write-first forwarding: lanes written on this same edge return the new data.
  always_comb begin
    rd_word = mem_q[bus.ReadAddr];
    for (int i = 0; i < LANES; i++) begin
      if (wr_acc && bus.WriteMask[i] && (bus.WriteAddr == bus.ReadAddr))
        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.WriteData[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Read-accept tag; cleared by reset so a pending read never completes.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) rd_valid_q <= 1'b0;
    else         rd_valid_q <= rd_acc;
  end

  // Array read register, kept reset-free so it maps onto block RAM.
  always_ff @(posedge Clock) begin
    if (rd_acc) rd_data_q <= rd_word;
  end

  sync_ram_read_pipe #(
    .WORD_WIDTH  (WORD_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .Clock  (Clock),
    .nReset (nReset),
    .valid_i(rd_valid_q),
    .data_i (rd_data_q),
    .valid_o(pipe_valid),
    .data_o (pipe_data)
  );

  assign bus.ReadValid = pipe_valid;
  assign bus.ReadData  = pipe_data;

endmodule
